addr_calc: RTL and testbench
============================

ADDR_CALC -- requirements
Module: addr_calc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named as below.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request; the instruction fields are valid in the same cycle.
REQ-005 aa  in  12  address field magnitude, AA (2 bytes).
REQ-006 asign  in  1  address sign; 1 means negative.
REQ-007 index  in  3  index register number I; 0 means no indexing, 1-6 select rI1-rI6, 7 is illegal.
REQ-008 field  in  6  F field, passed through.
REQ-009 opcode  in  6  C field, passed through.
REQ-010 ri_sel  out  3  index register file read select.
REQ-011 ri_data  in  12  register file read magnitude; valid one cycle after ri_sel is driven.
REQ-012 ri_sign  in  1  register file read sign; same timing as ri_data.
REQ-013 m  out  12  effective address magnitude; drives the execution units, including the shift unit's m input.
REQ-014 msign  out  1  effective address sign.
REQ-015 field_out  out  6  registered copy of field.
REQ-016 opcode_out  out  6  registered copy of opcode.
REQ-017 go  out  1  one-cycle start pulse to the execution unit selected by opcode_out.
REQ-018 stop  out  1  one-cycle completion pulse.
REQ-019 err  out  1  address fault flag; valid while stop is high.

Function
REQ-020 The FSM SHALL have four states: IDLE, FETCH, ADD and DONE.
REQ-021 In IDLE with start=1, the block SHALL capture aa, asign, index, field and opcode.
REQ-022 From IDLE with start=1, the next state SHALL be FETCH if index is 1-6, and ADD if index is 0 or 7.
REQ-023 In FETCH, ri_sel SHALL equal the captured index; FETCH SHALL always go to ADD.
REQ-024 In every state other than FETCH, ri_sel SHALL be 0.
REQ-025 In ADD, the operand SHALL be ri_data/ri_sign for index 1-6, and +0 for index 0 or 7.
REQ-026 In ADD, the sum SHALL be registered into m and msign; ADD SHALL always go to DONE.
REQ-027 In DONE, stop SHALL be 1 for exactly one cycle; DONE SHALL always go to IDLE.
REQ-028 In DONE, go SHALL be 1 only if err=0.
REQ-029 Latency SHALL be: index 1-6, stop and go 3 cycles after start; index 0 or 7, 2 cycles after start.
REQ-030 Addition SHALL be sign-magnitude. With equal signs: magnitude = aa + operand, sign = asign.
REQ-031 If that 13-bit sum has bit 12 set: err=1, and m SHALL hold the low 12 bits.
REQ-032 With differing signs: magnitude = larger minus smaller; sign = sign of the larger operand.
REQ-033 A zero result SHALL take sign asign.
REQ-034 Index 7 SHALL set err=1 and leave m = aa, msign = asign.
REQ-035 start while not in IDLE SHALL be ignored; there is no queueing.
REQ-036 m, msign, field_out, opcode_out and err SHALL hold their values until the next ADD state.
REQ-037 A start accepted in the same cycle as a DONE-to-IDLE transition is impossible, because DONE does not sample start; the next start is accepted in IDLE.

Reset
REQ-038 reset=1 SHALL force IDLE and zero all outputs: m, msign, field_out, opcode_out, go, stop, err and ri_sel.
REQ-039 reset SHALL take priority over start and over any in-progress state.
REQ-040 A reset asserted mid-operation SHALL abort the operation; no stop or go pulse SHALL follow.

Verification
REQ-041 start, aa=100, asign=0, index=0, opcode=6 (shift), field=2 -> stop and go at cycle +2; m=100, msign=0, field_out=2, err=0.
REQ-042 start, aa=5, asign=0, index=3; rI3=+20 -> ri_sel=3 at cycle +1; m=25, msign=0, stop at +3.
REQ-043 start, aa=5, asign=0, index=1; rI1=-20 -> m=15, msign=1; aa=20, asign=1, rI1=+20 -> m=0, msign=1.
REQ-044 aa=4000, asign=0, index=2; rI2=+200 -> err=1, m=104, stop=1, go=0.
REQ-045 index=7 -> err=1 at cycle +2, go=0, m=aa; a second start during FETCH is ignored, giving exactly one stop.
REQ-046 reset asserted in the FETCH cycle -> next cycle is IDLE, all outputs 0, no stop; a fresh start then completes normally.

Source files
------------

// File: rtl/addr_calc.sv
// Effective-address calculator: adds an optional index register to the
// sign-magnitude address field and hands the result to the execution units.
module addr_calc (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] aa,
   input  logic        asign,
   input  logic [2:0]  index,
   input  logic [5:0]  field,
   input  logic [5:0]  opcode,
   output logic [2:0]  ri_sel,
   input  logic [11:0] ri_data,
   input  logic        ri_sign,
   output logic [11:0] m,
   output logic        msign,
   output logic [5:0]  field_out,
   output logic [5:0]  opcode_out,
   output logic        go,
   output logic        stop,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, FETCH, ADD, DONE} state_t;

   state_t      state_reg, state_next;
   logic [11:0] aa_reg;
   logic        asign_reg;
   logic [2:0]  index_reg;
   logic [5:0]  field_reg;
   logic [5:0]  opcode_reg;

   logic        use_rf;
   logic [11:0] op_mag;
   logic        op_sign;
   logic [12:0] sum13;
   logic [11:0] sum_mag;
   logic        sum_sign;
   logic        sum_err;

   // Index 1-6 reads the register file; 0 and 7 (illegal) use +0 instead.
   assign use_rf = (index_reg != 3'd0) && (index_reg != 3'd7);

   // Next-state logic and Moore outputs (ri_sel, stop, go).
   always_comb begin
      state_next = state_reg;
      ri_sel     = 3'd0;
      stop       = 1'b0;
      go         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start)
               state_next = ((index != 3'd0) && (index != 3'd7)) ? FETCH : ADD;
         end
         FETCH: begin
            ri_sel     = index_reg;
            state_next = ADD;
         end
         ADD: begin
            state_next = DONE;
         end
         DONE: begin
            stop       = 1'b1;
            go         = ~err;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Sign-magnitude adder; a tie in magnitude keeps the address sign so zero takes asign.
   always_comb begin
      op_mag   = use_rf ? ri_data : 12'd0;
      op_sign  = use_rf ? ri_sign : 1'b0;
      sum13    = {1'b0, aa_reg} + {1'b0, op_mag};
      sum_mag  = sum13[11:0];
      sum_sign = asign_reg;
      sum_err  = sum13[12];
      if (op_sign != asign_reg) begin
         sum_err = 1'b0;
         if (aa_reg >= op_mag) begin
            sum_mag  = aa_reg - op_mag;
            sum_sign = asign_reg;
         end else begin
            sum_mag  = op_mag - aa_reg;
            sum_sign = op_sign;
         end
      end
      if (index_reg == 3'd7)
         sum_err = 1'b1;
   end

   // State register, instruction capture in IDLE, result registers loaded in ADD.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         aa_reg     <= 12'd0;
         asign_reg  <= 1'b0;
         index_reg  <= 3'd0;
         field_reg  <= 6'd0;
         opcode_reg <= 6'd0;
         m          <= 12'd0;
         msign      <= 1'b0;
         err        <= 1'b0;
         field_out  <= 6'd0;
         opcode_out <= 6'd0;
      end else begin
         state_reg <= state_next;
         if ((state_reg == IDLE) && start) begin
            aa_reg     <= aa;
            asign_reg  <= asign;
            index_reg  <= index;
            field_reg  <= field;
            opcode_reg <= opcode;
         end
         if (state_reg == ADD) begin
            m          <= sum_mag;
            msign      <= sum_sign;
            err        <= sum_err;
            field_out  <= field_reg;
            opcode_out <= opcode_reg;
         end
      end
   end

endmodule

// File: tb/tb_addr_calc.sv
// Directed bench for addr_calc with a result scoreboard and a register-file model.
module tb_addr_calc;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] aa;
   logic        asign;
   logic [2:0]  index;
   logic [5:0]  field;
   logic [5:0]  opcode;
   logic [2:0]  ri_sel;
   logic [11:0] ri_data;
   logic        ri_sign;
   logic [11:0] m;
   logic        msign;
   logic [5:0]  field_out;
   logic [5:0]  opcode_out;
   logic        go;
   logic        stop;
   logic        err;

   int tests = 0;
   int failures = 0;

   logic [11:0] rf_mag [8];
   logic        rf_sgn [8];

   typedef struct {
      logic [11:0] m;
      logic        msign;
      logic        err;
      logic [5:0]  field;
      logic [5:0]  opcode;
      int          lat;
   } exp_t;

   exp_t sb[$];

   addr_calc dut (
      .clk(clk), .reset(reset), .start(start), .aa(aa), .asign(asign),
      .index(index), .field(field), .opcode(opcode), .ri_sel(ri_sel),
      .ri_data(ri_data), .ri_sign(ri_sign), .m(m), .msign(msign),
      .field_out(field_out), .opcode_out(opcode_out), .go(go),
      .stop(stop), .err(err)
   );

   always #5 clk = ~clk;

   // Register file: read data appears one cycle after the select.
   always @(posedge clk) begin
      ri_data <= rf_mag[ri_sel];
      ri_sign <= rf_sgn[ri_sel];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model using signed integer arithmetic.
   function automatic exp_t model(input int a_mag, input bit a_s, input int idx,
                                  input int r_mag, input bit r_s,
                                  input logic [5:0] f, input logic [5:0] c);
      exp_t e;
      int a, o, s, mag;
      e.field  = f;
      e.opcode = c;
      e.lat    = (idx >= 1 && idx <= 6) ? 3 : 2;
      if (idx == 7) begin
         e.m = a_mag[11:0]; e.msign = a_s; e.err = 1'b1;
      end else begin
         a   = a_s ? -a_mag : a_mag;
         o   = (idx == 0) ? 0 : (r_s ? -r_mag : r_mag);
         s   = a + o;
         mag = (s < 0) ? -s : s;
         e.err   = (mag > 4095);
         e.m     = mag[11:0];
         e.msign = (s < 0) ? 1'b1 : (s > 0) ? 1'b0 : a_s;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction, optionally with an extra start one cycle later.
   task automatic run_op(input int a_mag, input bit a_s, input int idx,
                         input int f, input int c, input bit second);
      exp_t e;
      bit   seen = 0;
      int   extra = 0;
      logic [2:0] idx3 = idx[2:0];
      sb.push_back(model(a_mag, a_s, idx, int'(rf_mag[idx3]), rf_sgn[idx3], f[5:0], c[5:0]));
      start = 1'b1; aa = a_mag[11:0]; asign = a_s; index = idx3;
      field = f[5:0]; opcode = c[5:0];
      tick();
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         check("ri_sel", ri_sel, (k == 1 && idx >= 1 && idx <= 6) ? idx : 0);
         if (second && k == 1) begin
            start = 1'b1; aa = 12'd77; asign = 1'b0; index = 3'd0;
         end
         if (k == 2) start = 1'b0;
         if (stop) begin
            seen = 1;
            check("sb_nonempty", sb.size(), sb.size() == 0 ? 1 : sb.size());
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("latency", k, e.lat);
               check("m", m, e.m);
               check("msign", msign, e.msign);
               check("err", err, e.err);
               check("go", go, !e.err);
               check("field_out", field_out, e.field);
               check("opcode_out", opcode_out, e.opcode);
            end
            break;
         end
         tick();
      end
      start = 1'b0;
      check("stop_seen", seen, 1);
      for (int k = 0; k < 5; k++) begin
         tick();
         if (stop || go) extra++;
      end
      check("no_extra_stop", extra, 0);
   endtask

   initial begin
      int extra;
      for (int i = 0; i < 8; i++) begin
         rf_mag[i] = 12'd0; rf_sgn[i] = 1'b0;
      end
      reset = 1'b1; start = 1'b0; aa = '0; asign = 1'b0; index = '0;
      field = '0; opcode = '0;
      tick(); tick();
      check("rst_m", m, 0);
      check("rst_stop", stop, 0);
      check("rst_go", go, 0);
      check("rst_err", err, 0);
      check("rst_ri_sel", ri_sel, 0);
      check("rst_field_out", field_out, 0);
      reset = 1'b0;
      tick();

      rf_mag[1] = 12'd20;   rf_sgn[1] = 1'b1;
      rf_mag[2] = 12'd200;  rf_sgn[2] = 1'b0;
      rf_mag[3] = 12'd20;   rf_sgn[3] = 1'b0;
      rf_mag[4] = 12'd100;  rf_sgn[4] = 1'b1;
      rf_mag[5] = 12'd1;    rf_sgn[5] = 1'b1;
      rf_mag[6] = 12'd4095; rf_sgn[6] = 1'b1;

      run_op(100, 0, 0, 2, 6, 0);
      run_op(5, 0, 3, 9, 11, 0);
      run_op(5, 0, 1, 1, 1, 0);
      rf_sgn[1] = 1'b0;
      run_op(20, 1, 1, 3, 4, 0);
      run_op(4000, 0, 2, 5, 7, 0);
      run_op(321, 1, 7, 12, 13, 1);
      run_op(30, 1, 4, 14, 15, 0);
      run_op(4095, 1, 5, 16, 17, 0);
      run_op(500, 0, 6, 18, 19, 0);
      run_op(0, 1, 0, 20, 21, 0);
      run_op(8, 0, 3, 22, 23, 1);

      // Reset during FETCH aborts the operation.
      start = 1'b1; aa = 12'd9; asign = 1'b0; index = 3'd3; field = 6'd33; opcode = 6'd34;
      tick();
      start = 1'b0;
      check("abort_ri_sel_fetch", ri_sel, 3);
      reset = 1'b1;
      tick();
      check("abort_m", m, 0);
      check("abort_msign", msign, 0);
      check("abort_field_out", field_out, 0);
      check("abort_opcode_out", opcode_out, 0);
      check("abort_go", go, 0);
      check("abort_stop", stop, 0);
      check("abort_err", err, 0);
      check("abort_ri_sel", ri_sel, 0);
      reset = 1'b0;
      extra = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (stop || go) extra++;
      end
      check("abort_no_stop", extra, 0);
      run_op(9, 0, 3, 33, 34, 0);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
